// File: rtl/ins_mem_loader_pkg.sv
// ins_loader_pkg: shared definitions for the instruction-memory loader.
// Contents: loader FSM state encoding, default sync marker, default memory
// depth and the instruction-memory word-address width.
package ins_loader_pkg;

    localparam int unsigned MAX_WORDS = 512;
    localparam logic [7:0]  SYNC_BYTE = 8'hA5;
    localparam int unsigned ADDR_W    = 9;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CNT_LO = 3'd1,
        ST_CNT_HI = 3'd2,
        ST_DATA   = 3'd3,
        ST_CSUM   = 3'd4,
        ST_RUN    = 3'd5,
        ST_ERR    = 3'd6
    } state_e;

endpackage

// File: rtl/ins_mem_loader_step_sync.sv
// loader_step_sync: brings the asynchronous step push button into the clock
// domain (two flops) and produces a one-cycle pulse on each rising edge.
// Ports:
//   clk_i   - system clock
//   rst_ni  - asynchronous active-low reset
//   btn_i   - raw push-button level
//   rise_o  - one-cycle pulse per synchronised rising edge of btn_i
module loader_step_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_i,
    output logic rise_o
);

    logic [1:0] sync_q;
    logic       prev_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= 2'b00;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], btn_i};
            prev_q <= sync_q[1];
        end
    end

    assign rise_o = sync_q[1] & ~prev_q;

endmodule

// File: rtl/ins_mem_loader.sv
// ins_mem_loader: receives a program packet over a byte stream (UART),
// writes it into instruction memory and then releases the core, either
// free-running or single-stepped from a push button.
// Packet: SYNC, count_lo, count_hi, count x 4 bytes (little-endian words),
// XOR checksum of the data bytes.
//
// state     | meaning
// ----------+------------------------------------------------------
// ST_IDLE   | after reset, waiting for SYNC; core held
// ST_CNT_LO | expecting low byte of the word count
// ST_CNT_HI | expecting high byte, count range checked here
// ST_DATA   | collecting data bytes, one memory write per 4 bytes
// ST_CSUM   | expecting the checksum byte
// ST_RUN    | program loaded, core released
// ST_ERR    | packet rejected (range, checksum or timeout); core held
//
// Ports:
//   clk_i, rst_ni              - clock, asynchronous active-low reset
//   rx_valid_i, rx_data_i      - received byte strobe and data
//   step_mode_i, step_btn_i    - single-step enable, raw step button
//   mem_wr_en_o/addr_o/data_o  - instruction-memory write port
//   ins_mem_en_o, core_reset_o - core NOP-fetch and reset controls
//   pc_control_o               - core PC advance enable
//   done_o, error_o            - status of the last packet
module ins_mem_loader #(
    parameter int unsigned MAX_WORDS      = ins_loader_pkg::MAX_WORDS,
    parameter logic [7:0]  SYNC_BYTE      = ins_loader_pkg::SYNC_BYTE,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic                                rx_valid_i,
    input  logic [7:0]                          rx_data_i,
    input  logic                                step_mode_i,
    input  logic                                step_btn_i,
    output logic                                mem_wr_en_o,
    output logic [ins_loader_pkg::ADDR_W-1:0]   mem_wr_addr_o,
    output logic [31:0]                         mem_wr_data_o,
    output logic                                ins_mem_en_o,
    output logic                                core_reset_o,
    output logic                                pc_control_o,
    output logic                                done_o,
    output logic                                error_o
);
    import ins_loader_pkg::*;

    localparam int                 TMR_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMR_W-1:0]   TMR_LOAD = TMR_W'(TIMEOUT_CYCLES);
    localparam logic [15:0]        CNT_MAX  = 16'(MAX_WORDS);
    localparam logic [ADDR_W-1:0]  ADDR_MAX = ADDR_W'(MAX_WORDS - 1);

    state_e              state_q, state_d;
    logic [7:0]          cnt_lo_q, cnt_lo_d;
    logic [15:0]         words_left_q, words_left_d;
    logic [1:0]          byte_idx_q, byte_idx_d;
    logic [31:0]         data_q, data_d;
    logic [7:0]          csum_q, csum_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                wr_en_q, wr_en_d;
    logic                done_q, done_d;
    logic                error_q, error_d;
    logic [TMR_W-1:0]    tmr_q, tmr_d;

    logic                in_pkt;
    logic                timeout;
    logic [15:0]         cnt_full;
    logic                step_rise;

    loader_step_sync u_step_sync (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .btn_i  (step_btn_i),
        .rise_o (step_rise)
    );

    assign in_pkt   = (state_q == ST_CNT_LO) || (state_q == ST_CNT_HI) ||
                      (state_q == ST_DATA)   || (state_q == ST_CSUM);
    // Timeout beats a byte arriving in the same cycle.
    assign timeout  = in_pkt && (tmr_q == TMR_W'(1));
    assign cnt_full = {rx_data_i, cnt_lo_q};

    always_comb begin
        state_d      = state_q;
        cnt_lo_d     = cnt_lo_q;
        words_left_d = words_left_q;
        byte_idx_d   = byte_idx_q;
        data_d       = data_q;
        csum_d       = csum_q;
        addr_d       = addr_q;
        wr_en_d      = 1'b0;
        done_d       = done_q;
        error_d      = error_q;
        tmr_d        = tmr_q;

        // Advance after each write, saturating so the last word never wraps.
        if (wr_en_q && (addr_q != ADDR_MAX)) begin
            addr_d = addr_q + ADDR_W'(1);
        end

        if (in_pkt && !rx_valid_i) begin
            tmr_d = tmr_q - TMR_W'(1);
        end

        if (timeout) begin
            state_d = ST_ERR;
            error_d = 1'b1;
        end else if (rx_valid_i) begin
            tmr_d = TMR_LOAD;
            unique case (state_q)
                ST_IDLE, ST_RUN, ST_ERR: begin
                    if (rx_data_i == SYNC_BYTE) begin
                        state_d    = ST_CNT_LO;
                        addr_d     = '0;
                        csum_d     = '0;
                        byte_idx_d = '0;
                        done_d     = 1'b0;
                        error_d    = 1'b0;
                    end
                end
                ST_CNT_LO: begin
                    cnt_lo_d = rx_data_i;
                    state_d  = ST_CNT_HI;
                end
                ST_CNT_HI: begin
                    if ((cnt_full != 16'd0) && (cnt_full <= CNT_MAX)) begin
                        words_left_d = cnt_full;
                        state_d      = ST_DATA;
                    end else begin
                        state_d = ST_ERR;
                        error_d = 1'b1;
                    end
                end
                ST_DATA: begin
                    data_d[{byte_idx_q, 3'b000} +: 8] = rx_data_i;
                    csum_d     = csum_q ^ rx_data_i;
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        wr_en_d = 1'b1;
                        if (words_left_q == 16'd1) begin
                            state_d = ST_CSUM;
                        end else begin
                            words_left_d = words_left_q - 16'd1;
                        end
                    end
                end
                ST_CSUM: begin
                    if (rx_data_i == csum_q) begin
                        state_d = ST_RUN;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_ERR;
                        error_d = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_IDLE;
            cnt_lo_q     <= '0;
            words_left_q <= '0;
            byte_idx_q   <= '0;
            data_q       <= '0;
            csum_q       <= '0;
            addr_q       <= '0;
            wr_en_q      <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            tmr_q        <= '0;
        end else begin
            state_q      <= state_d;
            cnt_lo_q     <= cnt_lo_d;
            words_left_q <= words_left_d;
            byte_idx_q   <= byte_idx_d;
            data_q       <= data_d;
            csum_q       <= csum_d;
            addr_q       <= addr_d;
            wr_en_q      <= wr_en_d;
            done_q       <= done_d;
            error_q      <= error_d;
            tmr_q        <= tmr_d;
        end
    end

    // Core controls decode straight from the state register so a reload
    // from RUN holds the core in the cycle right after SYNC is accepted.
    assign ins_mem_en_o  = (state_q != ST_RUN);
    assign core_reset_o  = (state_q != ST_RUN);
    assign pc_control_o  = (state_q == ST_RUN) && (step_mode_i ? step_rise : 1'b1);
    assign mem_wr_en_o   = wr_en_q;
    assign mem_wr_addr_o = addr_q;
    assign mem_wr_data_o = data_q;
    assign done_o        = done_q;
    assign error_o       = error_q;

endmodule
